phase_controller: RTL

//  Sequences the multi-cycle (non-pipelined) RV32 core: FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK.

---
 rtl/phase_controller_pkg.sv | 19 +
 rtl/phase_controller_if.sv | 26 ++
 rtl/phase_controller_perf_counter.sv | 19 +
 rtl/phase_controller.sv | 102 ++++++++++
 4 files changed

// File: rtl/phase_controller_pkg.sv
// Shared definitions for the multi-cycle RV32 core sequencer.
// Holds the core-wide widths and the phase state encoding.
package phase_controller_pkg;

  localparam int XLEN        = 32;
  localparam int OPLEN       = 7;
  localparam int STATE_BIT_W = 3;

  // Binary state encoding, 0..5; curr_state exposes it for debug.
  typedef enum logic [STATE_BIT_W-1:0] {
    STATE_IDLE      = 3'd0,
    STATE_FETCH     = 3'd1,
    STATE_DECODE    = 3'd2,
    STATE_EXECUTE   = 3'd3,
    STATE_MEMORY    = 3'd4,
    STATE_WRITEBACK = 3'd5
  } state_e;

endpackage

// File: rtl/phase_controller_if.sv
// Stall inputs and phase enables between the sequencer and the core stages.
// The sequencer is the master: it drives phase_*, the stages drive stall_*.
interface phase_controller_if;

  logic stall_fetch;
  logic stall_decode;
  logic stall_execute;
  logic stall_memory;
  logic mem_access_de;
  logic phase_fetch;
  logic phase_decode;
  logic phase_execute;
  logic phase_memory;
  logic phase_writeback;

  modport master (
    input  stall_fetch, stall_decode, stall_execute, stall_memory, mem_access_de,
    output phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback
  );

  modport slave (
    output stall_fetch, stall_decode, stall_execute, stall_memory, mem_access_de,
    input  phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback
  );

endinterface

// File: rtl/phase_controller_perf_counter.sv
// Free-running event counter (mcycle / minstret style); wraps silently.
module perf_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count one per cycle with inc high; all-ones rolls over to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (inc) cnt <= cnt + ONE;
  end

endmodule

// File: rtl/phase_controller.sv
// Phase sequencer for the multi-cycle RV32 core:
// IDLE -> FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> FETCH.
// A stage's stall holds the state in that phase; phase_* are decoded
// combinationally from the registered state and the owning stall only.
// Optional: define SKIP_MEMORY_PHASE_EN to bypass MEMORY for non-load/store ops.
module phase_controller
  import phase_controller_pkg::*;
#(
  parameter int INIT_WAIT = 2,
  parameter int CNT_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  phase_controller_if.master     bus,
  output logic [STATE_BIT_W-1:0] curr_state,
  output logic [CNT_WIDTH-1:0]   cycle_cnt,
  output logic [CNT_WIDTH-1:0]   instret_cnt
);

  localparam int IDLE_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(INIT_WAIT - 1);

  state_e            state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              ph_fe, ph_de, ph_ex, ph_mem, ph_wb;

  // Phase enables: only the current state's own stall can mask its enable.
  always_comb begin
    ph_fe  = 1'b0;
    ph_de  = 1'b0;
    ph_ex  = 1'b0;
    ph_mem = 1'b0;
    ph_wb  = 1'b0;
    case (state)
      STATE_FETCH:     ph_fe  = ~bus.stall_fetch;
      STATE_DECODE:    ph_de  = ~bus.stall_decode;
      STATE_EXECUTE:   ph_ex  = ~bus.stall_execute;
      STATE_MEMORY:    ph_mem = ~bus.stall_memory;
      STATE_WRITEBACK: ph_wb  = 1'b1;
      default: ;
    endcase
  end

`ifndef SKIP_MEMORY_PHASE_EN
  // Every op visits MEMORY, so the decode hint has no consumer here.
  logic unused_mem_access;
  assign unused_mem_access = bus.mem_access_de;
`endif

  // Next state: advance exactly on the cycle the current phase enable fires.
  always_comb begin
    state_nxt = state;
    case (state)
      STATE_IDLE:      if (idle_cnt == IDLE_LAST) state_nxt = STATE_FETCH;
      STATE_FETCH:     if (ph_fe)  state_nxt = STATE_DECODE;
      STATE_DECODE:    if (ph_de)  state_nxt = STATE_EXECUTE;
      STATE_EXECUTE:   if (ph_ex) begin
`ifdef SKIP_MEMORY_PHASE_EN
        state_nxt = bus.mem_access_de ? STATE_MEMORY : STATE_WRITEBACK;
`else
        state_nxt = STATE_MEMORY;
`endif
      end
      STATE_MEMORY:    if (ph_mem) state_nxt = STATE_WRITEBACK;
      STATE_WRITEBACK: state_nxt = STATE_FETCH;
      default:         state_nxt = STATE_IDLE;
    endcase
  end

  // State register plus the post-reset idle wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STATE_IDLE;
      idle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == STATE_IDLE && idle_cnt != IDLE_LAST) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign bus.phase_fetch     = ph_fe;
  assign bus.phase_decode    = ph_de;
  assign bus.phase_execute   = ph_ex;
  assign bus.phase_memory    = ph_mem;
  assign bus.phase_writeback = ph_wb;
  assign curr_state          = state;

  perf_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state != STATE_IDLE),
    .cnt   (cycle_cnt)
  );

  perf_counter #(.WIDTH(CNT_WIDTH)) u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ph_wb),
    .cnt   (instret_cnt)
  );

endmodule
